kbd_event_sched: RTL

KBD_EVENT_SCHED -- requirements
Module: kbd_event_sched

---
 rtl/kbd_event_sched.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/kbd_event_sched.sv
// kbd_event_sched: queues key events from a toggle-strobe keyboard front end
// and hands them to a consumer one at a time, with a minimum idle gap
// between deliveries.
//
// Optional build macro: KBD_SCHED_OVERWRITE_EN
//   When defined, a push to a full FIFO in IDLE or GAP discards the oldest
//   event instead of the new one. The head being presented is never touched.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | nothing presented; moves to PRESENT once the FIFO is non-empty
// PRESENT | head event driven on evt_data with evt_valid=1 until evt_ack
// GAP     | enforced idle time after a delivery, gap_cnt counts down to 0
module kbd_event_sched #(
    parameter int          DEPTH      = 8,
    parameter logic [15:0] GAP_CYCLES = 16'd1024
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       kbd_strobe,
    input  logic [9:0] kbd_data,
    output logic       evt_valid,
    output logic [9:0] evt_data,
    input  logic       evt_ack,
    output logic       overflow,
    input  logic       ovf_clr,
    output logic [4:0] fifo_level
);

    localparam int         PTR_W   = $clog2(DEPTH);
    localparam logic [4:0] DEPTH_L = 5'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [9:0]       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] head_idx;
    logic [4:0]       count;
    logic [15:0]      gap_cnt;
    logic [15:0]      gap_cnt_nxt;
    logic             armed;
    logic             strobe_d;
    logic             push;
    logic             pop;
    logic             full;
    logic             accept;
    logic             drop_old;
    logic             lost;
    logic             load_head;

    // armed keeps a strobe level already present at reset release from
    // looking like an edge.
    assign push   = armed & (kbd_strobe != strobe_d);
    assign full   = (count == DEPTH_L);
    assign accept = push & (~full | pop);

`ifdef KBD_SCHED_OVERWRITE_EN
    assign drop_old = push & full & ~pop & (state != PRESENT);
    assign lost     = push & full & ~pop & (state == PRESENT);
`else
    assign drop_old = 1'b0;
    assign lost     = push & full & ~pop;
`endif

    // If the oldest entry is discarded in the same cycle it would be
    // presented, present the entry behind it instead.
    assign head_idx = drop_old ? rd_ptr + PTR_W'(1) : rd_ptr;

    assign fifo_level = count;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state, handshake and gap-timer control.
    always_comb begin
        state_nxt   = state;
        gap_cnt_nxt = gap_cnt;
        pop         = 1'b0;
        load_head   = 1'b0;
        evt_valid   = 1'b0;
        case (state)
            IDLE: begin
                if (count != 5'd0) begin
                    state_nxt = PRESENT;
                    load_head = 1'b1;
                end
            end
            PRESENT: begin
                evt_valid = 1'b1;
                if (evt_ack) begin
                    pop = 1'b1;
                    if (GAP_CYCLES == 16'd0) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt   = GAP;
                        gap_cnt_nxt = GAP_CYCLES - 16'd1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == 16'd0) state_nxt = IDLE;
                else                  gap_cnt_nxt = gap_cnt - 16'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strobe edge detect, FIFO pointers/level, presented data and overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed    <= 1'b0;
            strobe_d <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= 5'd0;
            gap_cnt  <= 16'd0;
            evt_data <= 10'h000;
            overflow <= 1'b0;
        end else begin
            armed    <= 1'b1;
            strobe_d <= kbd_strobe;
            gap_cnt  <= gap_cnt_nxt;
            if (accept | drop_old) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop | drop_old)    rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + {4'd0, accept} - {4'd0, pop};
            if (load_head) evt_data <= mem[head_idx];
            if (lost | drop_old) overflow <= 1'b1;
            else if (ovf_clr)    overflow <= 1'b0;
        end
    end

    // Event storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (accept | drop_old) mem[wr_ptr] <= kbd_data;
    end

endmodule
